trace_serialiser: RTL and testbench

- Consumer end of the trace record path.
- Accepts complete trace_format records (160 bits) from the tracer over a valid/ready handshake and buffers them in a small FIFO.
- Emits each record as five 32-bit words on an AXI-Stream-style master port, with tlast on the final word.
- Sits between the trace generator and the off-chip or DMA trace sink.

---
 rtl/trace_serialiser_pkg.sv | 29 ++
 rtl/trace_serialiser_fifo.sv | 49 ++++
 rtl/trace_serialiser.sv | 108 ++++++++++
 tb/tb_trace_serialiser.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_serialiser_pkg.sv
// Shared trace record types and helpers for the trace sink path.
package trace_serialiser_pkg;

  // One trace record as produced by the tracer; instruction is the MSB word.
  typedef struct packed {
    logic [31:0] instruction;
    logic [31:0] instr_addr;
    logic [31:0] mem_addr;
    logic [31:0] mem_trans_time_start;
    logic [31:0] mem_trans_time_end;
  } trace_format;

  localparam int TRACE_WORDS     = 5;
  localparam int TRACE_REC_WIDTH = $bits(trace_format);

  typedef enum logic {IDLE, SEND} serialiser_state_t;

  // Word ordering on the stream: instruction first, end timestamp last.
  function automatic logic [31:0] trace_word(input trace_format r, input logic [2:0] idx);
    case (idx)
      3'd0:    trace_word = r.instruction;
      3'd1:    trace_word = r.instr_addr;
      3'd2:    trace_word = r.mem_addr;
      3'd3:    trace_word = r.mem_trans_time_start;
      default: trace_word = r.mem_trans_time_end;
    endcase
  endfunction

endpackage

// File: rtl/trace_serialiser_fifo.sv
// Synchronous FIFO of whole trace records; head is readable combinationally.
module trace_record_fifo
  import trace_serialiser_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  trace_format              push_data,
  input  logic                     pop,
  output trace_format              pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  trace_format   mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign level    = wr_ptr - rd_ptr;
  assign full     = (level == (AW+1)'(DEPTH));
  assign empty    = (wr_ptr == rd_ptr);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // Pointer update; both may move in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since the pointers gate reads.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/trace_serialiser.sv
// Buffers 160-bit trace records and streams each as five 32-bit words.
module trace_serialiser
  import trace_serialiser_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [TRACE_REC_WIDTH-1:0]    rec_in,
  input  logic                          rec_valid,
  output logic                          rec_ready,
  output logic [31:0]                   m_tdata,
  output logic                          m_tvalid,
  output logic                          m_tlast,
  input  logic                          m_tready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [CNT_WIDTH-1:0]          bp_cycles
);
  localparam logic [2:0] LAST_IDX = 3'(TRACE_WORDS - 1);

  serialiser_state_t state;
  trace_format       hold;
  trace_format       head;
  logic [2:0]        word_idx;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              last_hs;

  // No pop bypass: a full buffer refuses even if it drains this cycle.
  assign rec_ready = !rst && !full;
  assign push      = rec_valid && rec_ready;
  assign last_hs   = (state == SEND) && m_tvalid && m_tready && (word_idx == LAST_IDX);
  assign pop       = !empty && ((state == IDLE) || last_hs);

  trace_record_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (trace_format'(rec_in)),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .level     (fifo_level)
  );

  // Saturating count of cycles where the tracer was held off.
  always_ff @(posedge clk) begin
    if (rst)
      bp_cycles <= '0;
    else if (rec_valid && !rec_ready && (bp_cycles != {CNT_WIDTH{1'b1}}))
      bp_cycles <= bp_cycles + 1'b1;
  end

  // Output FSM: IDLE loads the holding register, SEND walks its five words.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      hold     <= '0;
      word_idx <= '0;
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
      m_tdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            hold     <= head;
            word_idx <= '0;
            state    <= SEND;
          end
        end
        SEND: begin
          if (!m_tvalid) begin
            // First word of a record loaded from IDLE.
            m_tvalid <= 1'b1;
            m_tdata  <= trace_word(hold, 3'd0);
            m_tlast  <= 1'b0;
          end else if (m_tready) begin
            if (word_idx == LAST_IDX) begin
              if (!empty) begin
                // Chain straight into the next record, no bubble.
                hold     <= head;
                word_idx <= '0;
                m_tdata  <= trace_word(head, 3'd0);
                m_tlast  <= 1'b0;
              end else begin
                state    <= IDLE;
                word_idx <= '0;
                m_tvalid <= 1'b0;
                m_tlast  <= 1'b0;
              end
            end else begin
              word_idx <= word_idx + 3'd1;
              m_tdata  <= trace_word(hold, word_idx + 3'd1);
              m_tlast  <= (word_idx + 3'd1 == LAST_IDX);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trace_serialiser.sv
// Directed bench for trace_serialiser: latency, backpressure, fill, reset, wrap, saturation.
module tb_trace_serialiser;
  import trace_serialiser_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic [159:0] rec_in = '0;
  logic         rec_valid = 1'b0;
  logic         rec_ready;
  logic [31:0]  m_tdata;
  logic         m_tvalid;
  logic         m_tlast;
  logic         m_tready = 1'b0;
  logic [2:0]   fifo_level;
  logic [31:0]  bp_cycles;

  logic         s_rst = 1'b1;
  logic [159:0] s_rec_in = '0;
  logic         s_rec_valid = 1'b0;
  logic         s_rec_ready;
  logic [31:0]  s_tdata;
  logic         s_tvalid;
  logic         s_tlast;
  logic         s_tready = 1'b0;
  logic [2:0]   s_level;
  logic [3:0]   s_bp;

  trace_serialiser #(.FIFO_DEPTH(4), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .rec_in(rec_in), .rec_valid(rec_valid), .rec_ready(rec_ready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .fifo_level(fifo_level), .bp_cycles(bp_cycles)
  );

  trace_serialiser #(.FIFO_DEPTH(4), .CNT_WIDTH(4)) u_sat (
    .clk(clk), .rst(s_rst), .rec_in(s_rec_in), .rec_valid(s_rec_valid), .rec_ready(s_rec_ready),
    .m_tdata(s_tdata), .m_tvalid(s_tvalid), .m_tlast(s_tlast), .m_tready(s_tready),
    .fifo_level(s_level), .bp_cycles(s_bp)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [32:0] mon_q[$];
  int          mon_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Record every accepted stream word with its cycle stamp.
  always @(posedge clk) begin
    if (!rst && m_tvalid && m_tready) begin
      mon_q.push_back({m_tlast, m_tdata});
      mon_cyc.push_back(cyc);
    end
  end

  function automatic trace_format mk(input int k);
    trace_format r;
    r.instruction          = 32'hA000_0000 | (32'(k) << 8);
    r.instr_addr           = 32'hB000_0001 | (32'(k) << 8);
    r.mem_addr             = 32'hC000_0002 | (32'(k) << 8);
    r.mem_trans_time_start = 32'hD000_0003 | (32'(k) << 8);
    r.mem_trans_time_end   = 32'hE000_0004 | (32'(k) << 8);
    return r;
  endfunction

  function automatic logic [31:0] fld(input trace_format r, input int i);
    case (i)
      0:       return r.instruction;
      1:       return r.instr_addr;
      2:       return r.mem_addr;
      3:       return r.mem_trans_time_start;
      default: return r.mem_trans_time_end;
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; rec_valid = 1'b0; m_tready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    mon_q.delete(); mon_cyc.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; rec_valid = 1'b1; m_tready = 1'b0;
    @(negedge clk);
    total++;
    if (rec_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", rec_ready); end
    total++;
    if ({m_tvalid, m_tlast, m_tdata} !== 34'h0) begin
      bad++; $display("FAIL reset_out: got v=%b l=%b d=%h want 0", m_tvalid, m_tlast, m_tdata);
    end
    total++;
    if (bp_cycles !== 32'd0 || fifo_level !== 3'd0) begin
      bad++; $display("FAIL reset_cnt: got bp=%0d lvl=%0d want 0", bp_cycles, fifo_level);
    end
    rst = 1'b0; rec_valid = 1'b0;
    #1;
    total++;
    if (rec_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready: got %b want 1", rec_ready); end
  endtask

  task automatic test_single();
    trace_format r;
    logic [31:0] exp [5];
    exp = '{32'h13, 32'h80, 32'h1000, 32'h10, 32'h14};
    r.instruction = 32'h13; r.instr_addr = 32'h80; r.mem_addr = 32'h1000;
    r.mem_trans_time_start = 32'h10; r.mem_trans_time_end = 32'h14;
    mon_q.delete(); mon_cyc.delete();
    @(negedge clk);
    rec_in = r; rec_valid = 1'b1; m_tready = 1'b1;
    @(negedge clk);
    rec_valid = 1'b0;
    total++;
    if (m_tvalid !== 1'b0) begin bad++; $display("FAIL single_lat1: tvalid=%b want 0", m_tvalid); end
    @(negedge clk);
    total++;
    if (m_tvalid !== 1'b0) begin bad++; $display("FAIL single_lat2: tvalid=%b want 0", m_tvalid); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if ({m_tvalid, m_tlast, m_tdata} !== {1'b1, (i == 4), exp[i]}) begin
        bad++;
        $display("FAIL single_word%0d: got v=%b l=%b d=%h want v=1 l=%b d=%h",
                 i, m_tvalid, m_tlast, m_tdata, (i == 4), exp[i]);
      end
    end
    @(negedge clk);
    total++;
    if (m_tvalid !== 1'b0 || mon_q.size() != 5) begin
      bad++; $display("FAIL single_end: tvalid=%b words=%0d want 0/5", m_tvalid, mon_q.size());
    end
    m_tready = 1'b0;
  endtask

  task automatic test_backpressure();
    trace_format r;
    int pat [4];
    logic        stalled;
    logic [33:0] snap;
    int          k;
    pat = '{1, 0, 0, 1};
    r = mk(1);
    do_reset();
    @(negedge clk);
    rec_in = r; rec_valid = 1'b1; m_tready = 1'b1;
    stalled = 1'b0; snap = '0; k = 0;
    while (mon_q.size() < 5 && k < 60) begin
      @(negedge clk);
      rec_valid = 1'b0;
      if (stalled) begin
        total++;
        if ({m_tvalid, m_tlast, m_tdata} !== snap) begin
          bad++; $display("FAIL bp_stable: got %h want %h", {m_tvalid, m_tlast, m_tdata}, snap);
        end
      end
      m_tready = pat[k % 4][0];
      stalled  = m_tvalid && !m_tready;
      snap     = {m_tvalid, m_tlast, m_tdata};
      k++;
    end
    total++;
    if (k >= 60) begin bad++; $display("FAIL bp_timeout: words=%0d want 5", mon_q.size()); end
    m_tready = 1'b1;
    repeat (8) @(negedge clk);
    total++;
    if (mon_q.size() != 5) begin bad++; $display("FAIL bp_count: got %0d want 5", mon_q.size()); end
    for (int i = 0; i < 5 && i < mon_q.size(); i++) begin
      total++;
      if (mon_q[i] !== {(i == 4), fld(r, i)}) begin
        bad++; $display("FAIL bp_word%0d: got %h want %h", i, mon_q[i], {(i == 4), fld(r, i)});
      end
    end
    m_tready = 1'b0;
  endtask

  task automatic test_fill();
    trace_format recs [6];
    int i, blocked, guard;
    logic released;
    for (int n = 0; n < 6; n++) recs[n] = mk(n + 2);
    do_reset();
    i = 0; blocked = 0; guard = 0; released = 1'b0;
    while (i < 6 && guard < 100) begin
      @(negedge clk);
      if (!released && blocked == 5) begin
        total++;
        if (fifo_level !== 3'd4 || rec_ready !== 1'b0) begin
          bad++; $display("FAIL fill_full: lvl=%0d ready=%b want 4/0", fifo_level, rec_ready);
        end
        total++;
        if (bp_cycles !== 32'd5) begin bad++; $display("FAIL fill_bp: got %0d want 5", bp_cycles); end
        m_tready = 1'b1; released = 1'b1;
      end
      rec_in = recs[i]; rec_valid = 1'b1;
      if (rec_ready) i++; else blocked++;
      guard++;
    end
    @(negedge clk);
    rec_valid = 1'b0;
    guard = 0;
    while (mon_q.size() < 30 && guard < 100) begin @(negedge clk); guard++; end
    total++;
    if (mon_q.size() < 30) begin bad++; $display("FAIL fill_timeout: words=%0d want 30", mon_q.size()); end
    for (int n = 0; n < 30 && n < mon_q.size(); n++) begin
      total++;
      if (mon_q[n] !== {(n % 5 == 4), fld(recs[n / 5], n % 5)}) begin
        bad++; $display("FAIL fill_word%0d: got %h want %h", n, mon_q[n], {(n % 5 == 4), fld(recs[n / 5], n % 5)});
      end
      if (n > 0) begin
        total++;
        if (mon_cyc[n] != mon_cyc[n-1] + 1) begin
          bad++; $display("FAIL fill_gap%0d: cycle %0d want %0d", n, mon_cyc[n], mon_cyc[n-1] + 1);
        end
      end
    end
    total++;
    if (bp_cycles !== 32'(blocked)) begin bad++; $display("FAIL fill_bp_total: got %0d want %0d", bp_cycles, blocked); end
    m_tready = 1'b0;
  endtask

  task automatic test_reset_mid();
    trace_format r;
    int guard;
    do_reset();
    @(negedge clk);
    rec_in = mk(20); rec_valid = 1'b1; m_tready = 1'b1;
    @(negedge clk);
    rec_valid = 1'b0;
    guard = 0;
    while (mon_q.size() < 2 && guard < 20) begin @(negedge clk); guard++; end
    total++;
    if (mon_q.size() != 2) begin bad++; $display("FAIL rmid_pre: words=%0d want 2", mon_q.size()); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (m_tvalid !== 1'b0 || fifo_level !== 3'd0 || bp_cycles !== 32'd0) begin
      bad++; $display("FAIL rmid_state: v=%b lvl=%0d bp=%0d want 0/0/0", m_tvalid, fifo_level, bp_cycles);
    end
    mon_q.delete(); mon_cyc.delete();
    r = mk(21);
    rec_in = r; rec_valid = 1'b1;
    @(negedge clk);
    rec_valid = 1'b0;
    guard = 0;
    while (mon_q.size() < 5 && guard < 20) begin @(negedge clk); guard++; end
    repeat (3) @(negedge clk);
    total++;
    if (mon_q.size() != 5) begin bad++; $display("FAIL rmid_count: got %0d want 5", mon_q.size()); end
    for (int i = 0; i < 5 && i < mon_q.size(); i++) begin
      total++;
      if (mon_q[i] !== {(i == 4), fld(r, i)}) begin
        bad++; $display("FAIL rmid_word%0d: got %h want %h", i, mon_q[i], {(i == 4), fld(r, i)});
      end
    end
    m_tready = 1'b0;
  endtask

  task automatic test_simul();
    int pushed, guard;
    logic pend;
    do_reset();
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      rec_in = mk(40 + n); rec_valid = 1'b1;
    end
    @(negedge clk);
    rec_valid = 1'b0;
    total++;
    if (fifo_level !== 3'd2) begin bad++; $display("FAIL simul_start: lvl=%0d want 2", fifo_level); end
    m_tready = 1'b1;
    pushed = 3; guard = 0; pend = 1'b0;
    while (mon_q.size() < 60 && guard < 200) begin
      @(negedge clk);
      if (pend) begin
        total++;
        if (fifo_level !== 3'd2) begin bad++; $display("FAIL simul_level: lvl=%0d want 2", fifo_level); end
      end
      pend = 1'b0;
      if (m_tvalid && m_tlast && pushed < 12) begin
        rec_in = mk(40 + pushed); rec_valid = 1'b1; pushed++; pend = 1'b1;
      end else begin
        rec_valid = 1'b0;
      end
      guard++;
    end
    rec_valid = 1'b0;
    total++;
    if (mon_q.size() != 60) begin bad++; $display("FAIL simul_count: got %0d want 60", mon_q.size()); end
    for (int n = 0; n < 60 && n < mon_q.size(); n++) begin
      total++;
      if (mon_q[n] !== {(n % 5 == 4), fld(mk(40 + n / 5), n % 5)}) begin
        bad++; $display("FAIL simul_word%0d: got %h want %h", n, mon_q[n], {(n % 5 == 4), fld(mk(40 + n / 5), n % 5)});
      end
    end
    m_tready = 1'b0;
  endtask

  task automatic test_saturation();
    @(negedge clk);
    s_rst = 1'b0; s_rec_in = mk(99); s_rec_valid = 1'b1; s_tready = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (k == 10) begin
        total++;
        if (s_bp !== 4'd6) begin bad++; $display("FAIL sat_mid: got %0d want 6", s_bp); end
      end
      if (k == 18) begin
        total++;
        if (s_bp !== 4'd14) begin bad++; $display("FAIL sat_pre: got %0d want 14", s_bp); end
      end
      if (k == 19) begin
        total++;
        if (s_bp !== 4'd15) begin bad++; $display("FAIL sat_hit: got %0d want 15", s_bp); end
      end
    end
    total++;
    if (s_bp !== 4'hF) begin bad++; $display("FAIL sat_hold: got %0d want 15", s_bp); end
    s_rec_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_fill();
    test_reset_mid();
    test_simul();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
